// File: rtl/crc_pkg.sv
// Shared constants, FSM state type and the byte-wide CRC16-USB step for the frame writer.
package crc_pkg;

  localparam logic [15:0] CRC16_USB_INIT      = 16'hFFFF;
  localparam logic [15:0] CRC16_USB_XOROUT    = 16'hFFFF;
  localparam logic [15:0] CRC16_USB_POLY_REFL = 16'hA001;

  typedef enum logic [2:0] {
    IDLE,
    DATA,
    CRC_LO,
    CRC_HI,
    DONE
  } wr_state_e;

  // LSB-first (reflected) update: one full byte per call.
  function automatic logic [15:0] crc16_usb_byte(input logic [15:0] crc, input logic [7:0] data);
    logic [15:0] c;
    c = crc ^ {8'h00, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC16_USB_POLY_REFL) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/crc_frame_writer_if.sv
// Byte stream into the frame writer: valid/ready handshake with an end-of-frame marker.
interface crc_frame_writer_if;
  logic [7:0] data_in;
  logic       data_valid;
  logic       data_last;
  logic       data_ready;

  modport master (output data_in, output data_valid, output data_last, input data_ready);
  modport slave  (input data_in, input data_valid, input data_last, output data_ready);
endinterface

// File: rtl/crc16_usb_acc.sv
// Running CRC16-USB register: reloads on init, folds in one byte per enabled cycle.
module crc16_usb_acc
  import crc_pkg::*;
(
  input  logic        clk50m,
  input  logic        rst,
  input  logic        init,
  input  logic        en,
  input  logic [7:0]  data,
  output logic [15:0] crc
);

  always_ff @(posedge clk50m) begin
    if (rst || init) begin
      crc <= CRC16_USB_INIT;
    end else if (en) begin
      crc <= crc16_usb_byte(crc, data);
    end
  end

endmodule

// File: rtl/crc_frame_writer.sv
// Writes a payload stream to memory, then (with CRC_FRAME_APPEND_EN defined) appends its
// CRC16-USB low byte first; reports length, CRC and overflow with a one-cycle frm_rdy.
module crc_frame_writer
  import crc_pkg::*;
#(
  parameter logic [9:0] BASE_ADDR = 10'd0,
  parameter int         MAX_LEN   = 1022
) (
  input  logic                      clk50m,
  input  logic                      rst,
  input  logic                      frm_start,
  crc_frame_writer_if.slave         stream,
  output logic [9:0]                mem_addr,
  output logic [7:0]                mem_wdata,
  output logic                      mem_we,
  output logic [15:0]               crc_out,
  output logic [9:0]                frm_len,
  output logic                      frm_rdy,
  output logic                      frm_err
);

`ifdef CRC_FRAME_APPEND_EN
  localparam bit APPEND_EN = 1'b1;
`else
  localparam bit APPEND_EN = 1'b0;
`endif

  localparam logic [9:0] MAX_CNT = 10'(MAX_LEN);

  wr_state_e   state;
  logic [9:0]  byte_cnt;
  logic        ovf;
  logic [15:0] crc_reg;
  logic [15:0] crc_final;
  logic        acc_init;
  logic        acc_en;

  assign acc_init  = (state == IDLE) && frm_start;
  assign acc_en    = (state == DATA) && stream.data_valid;
  assign crc_final = crc_reg ^ CRC16_USB_XOROUT;

  crc16_usb_acc u_crc (
    .clk50m (clk50m),
    .rst    (rst),
    .init   (acc_init),
    .en     (acc_en),
    .data   (stream.data_in),
    .crc    (crc_reg)
  );

  always_ff @(posedge clk50m) begin
    if (rst) begin
      state             <= IDLE;
      byte_cnt          <= '0;
      ovf               <= 1'b0;
      stream.data_ready <= 1'b0;
      mem_we            <= 1'b0;
      mem_addr          <= '0;
      mem_wdata         <= '0;
      crc_out           <= '0;
      frm_len           <= '0;
      frm_rdy           <= 1'b0;
      frm_err           <= 1'b0;
    end else begin
      mem_we  <= 1'b0;
      frm_rdy <= 1'b0;
      case (state)
        IDLE: begin
          if (frm_start) begin
            state             <= DATA;
            byte_cnt          <= '0;
            ovf               <= 1'b0;
            frm_err           <= 1'b0;
            stream.data_ready <= 1'b1;
          end
        end
        DATA: begin
          if (stream.data_valid) begin
            mem_we    <= 1'b1;
            mem_addr  <= BASE_ADDR + byte_cnt;
            mem_wdata <= stream.data_in;
            byte_cnt  <= byte_cnt + 10'd1;
            if (stream.data_last) begin
              state             <= CRC_LO;
              stream.data_ready <= 1'b0;
            end else if (byte_cnt == MAX_CNT - 10'd1) begin
              // Buffer full without an end marker: keep the byte, skip the CRC tail.
              state             <= DONE;
              ovf               <= 1'b1;
              stream.data_ready <= 1'b0;
            end
          end
        end
        CRC_LO: begin
          if (APPEND_EN) begin
            mem_we    <= 1'b1;
            mem_addr  <= BASE_ADDR + byte_cnt;
            mem_wdata <= crc_final[7:0];
            state     <= CRC_HI;
          end else begin
            frm_rdy <= 1'b1;
            crc_out <= crc_final;
            frm_len <= byte_cnt;
            state   <= IDLE;
          end
        end
        CRC_HI: begin
          mem_we    <= 1'b1;
          mem_addr  <= BASE_ADDR + byte_cnt + 10'd1;
          mem_wdata <= crc_final[15:8];
          state     <= DONE;
        end
        DONE: begin
          frm_rdy <= 1'b1;
          frm_err <= ovf;
          crc_out <= crc_final;
          frm_len <= byte_cnt;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/crc_frame_writer.md
CRC_FRAME_WRITER -- requirements
Module: crc_frame_writer

Interface
REQ-001 Parameter BASE_ADDR, default 10'd0: memory address of the first payload byte.
REQ-002 Parameter MAX_LEN, default 1022: maximum payload bytes per frame; BASE_ADDR+MAX_LEN+1 SHALL be <= 1023.
REQ-003 clk50m  in  1  single clock; all logic SHALL be on its rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 frm_start  in  1  one-cycle pulse; starts a new frame.
REQ-006 data_in  in  8  payload byte.
REQ-007 data_valid  in  1  data_in valid.
REQ-008 data_last  in  1  qualifies the final payload byte; sampled only when a byte is accepted.
REQ-009 data_ready  out  1  writer accepts a byte; a transfer occurs when data_valid and data_ready are both high.
REQ-010 mem_addr  out  10  write address.
REQ-011 mem_wdata  out  8  write data.
REQ-012 mem_we  out  1  one-cycle write strobe.
REQ-013 crc_out  out  16  final CRC16-USB of the payload.
REQ-014 frm_len  out  10  number of payload bytes written.
REQ-015 frm_rdy  out  1  one-cycle pulse at frame completion.
REQ-016 frm_err  out  1  overflow flag.

Function
REQ-017 CRC SHALL be CRC16-USB: poly 0x8005, reflected in/out (0xA001 shift-right form), init 0xFFFF, xorout 0xFFFF, one byte per cycle.
REQ-018 The FSM SHALL use states IDLE, DATA, CRC_LO, CRC_HI, DONE.
REQ-019 IDLE: data_ready=0; frm_start -> DATA, CRC register=0xFFFF, byte count=0, frm_err=0, frm_rdy=0.
REQ-020 DATA: data_ready=1; each accepted byte SHALL update the CRC and increment the count. The byte SHALL be written at BASE_ADDR+count(before increment) with mem_we high in the following cycle.
REQ-021 Cycles with data_valid=0 in DATA SHALL change nothing; gaps of any length are legal.
REQ-022 An accepted byte with data_last=1 SHALL move the FSM to CRC_LO; data_ready SHALL be 0 from the next cycle.
REQ-023 If the last payload write occurs in cycle k, the low CRC byte (final, xored) SHALL be written at BASE_ADDR+N in k+1 and the high byte at BASE_ADDR+N+1 in k+2. frm_rdy SHALL pulse in k+3, and the FSM SHALL then return to IDLE.
REQ-024 crc_out and frm_len SHALL update in the frm_rdy cycle and hold until the next frm_start.
REQ-025 Overflow: if the MAX_LEN-th byte is accepted with data_last=0, that byte SHALL still be written, but no CRC SHALL be written. frm_err=1 and frm_rdy SHALL pulse in the cycle after that write, and the FSM SHALL go to IDLE. frm_err SHALL hold until the next frm_start.
REQ-026 frm_start outside IDLE SHALL be ignored.
REQ-027 mem_we SHALL never be high for two writes to the same address within one frame.

Reset
REQ-028 rst SHALL force IDLE in the next cycle from any state, including mid-frame. No further mem_we SHALL occur for the aborted frame.
REQ-029 Reset values: data_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, crc_out=0, frm_len=0, frm_rdy=0, frm_err=0, CRC register=0xFFFF.

Configuration
REQ-030 Macro CRC_FRAME_APPEND_EN SHALL control CRC appending.
- Defined: CRC bytes are appended to memory per REQ-023.
- Undefined: CRC_LO/CRC_HI perform no writes; frm_rdy pulses in k+1; crc_out is still produced.

Structure
REQ-031 The FSM state enum, CRC16_USB_INIT (0xFFFF), CRC16_USB_XOROUT (0xFFFF) and the reflected polynomial constant (0xA001) SHALL reside in package crc_pkg.
REQ-032 The per-byte CRC register with init/enable SHALL be sub-module crc16_usb_acc; the FSM and address counter SHALL stay in crc_frame_writer.

Verification
REQ-033 The bench SHALL cover these scenarios:
- Payload "123456789" (0x31..0x39), data_last on 0x39 -> crc_out=0xB4C8, frm_len=9, mem[9]=0xC8, mem[10]=0xB4, frm_rdy one cycle.
- Single byte 0x00 with data_last -> crc_out=0xBF40, mem[0]=0x00, mem[1]=0x40, mem[2]=0xBF.
- "123456789" with data_valid low for 3 cycles between every byte -> same results as the first scenario; no spurious mem_we.
- MAX_LEN=4, 5 bytes without data_last -> 4 writes, frm_err=1, frm_rdy pulse, no CRC write, data_ready=0 afterwards.
- rst asserted after the 3rd byte -> IDLE next cycle, all outputs at reset values, no further writes. A new frame then completes correctly.
- frm_start pulsed in DATA -> ignored; frame count and CRC unaffected.
